call_register: RTL and testbench

CALL_REGISTER -- requirements
Module: call_register

---
 rtl/elevator_pkg.sv | 12 +
 rtl/button_debouncer.sv | 84 ++++++++
 rtl/call_register.sv | 58 +++++
 tb/tb_call_register.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator constants: floor count, default debounce depth and floor indices.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS        = 3;
  localparam int unsigned DB_CYCLES_DEFAULT = 4;
  localparam int unsigned DB_CNT_W          = 8;

  localparam int unsigned FLOOR_1 = 0;
  localparam int unsigned FLOOR_2 = 1;
  localparam int unsigned FLOOR_3 = 2;

endpackage

// File: rtl/button_debouncer.sv
// One floor: synchronizes the car and hall button, filters the combined press and
// emits a one-cycle pulse on a debounced rise. Counter present only with CALL_REGISTER_DEBOUNCE_EN.
module button_debouncer
  import elevator_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic interior_i,
  input  logic exterior_i,
  output logic rise_c
);

  logic [1:0] int_sync_q;
  logic [1:0] ext_sync_q;
  logic       press;
  logic       level_q;
  logic       level_d;

  // Out-of-range depths leave an empty marker scope visible in the elaborated hierarchy.
  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_db_cycles_out_of_range
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      int_sync_q <= 2'b00;
      ext_sync_q <= 2'b00;
    end else begin
      int_sync_q <= {int_sync_q[0], interior_i};
      ext_sync_q <= {ext_sync_q[0], exterior_i};
    end
  end

  assign press = int_sync_q[1] | ext_sync_q[1];

`ifdef CALL_REGISTER_DEBOUNCE_EN
  localparam logic [DB_CNT_W-1:0] CntMax = DB_CNT_W'(DB_CYCLES);

  logic                prev_q;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;

  // Level follows press on the edge that completes DB_CYCLES stable samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (press != prev_q) begin
      cnt_d = '0;
    end else begin
      if (cnt_q < CntMax) begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
      if (cnt_q >= CntMax - DB_CNT_W'(1)) begin
        level_d = press;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= press;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign level_d = press;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  // Pulse is taken from the next level so the request register sees it on the same edge.
  assign rise_c = level_d & ~level_q;

endmodule

// File: rtl/call_register.sv
// Elevator call register: latches debounced floor calls until the doors open there.
// Debounce filtering is compiled in with CALL_REGISTER_DEBOUNCE_EN.
module call_register #(
  parameter int unsigned NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int unsigned DB_CYCLES  = elevator_pkg::DB_CYCLES_DEFAULT
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_FLOORS-1:0]               interior_panel,
  input  logic [NUM_FLOORS-1:0]               exterior_panel,
  input  logic [NUM_FLOORS-1:0]               doors,
  output logic [NUM_FLOORS-1:0]               requests,
  output logic [$clog2(NUM_FLOORS+1)-1:0]     req_count
);

  localparam int unsigned CntW = $clog2(NUM_FLOORS + 1);

  logic [NUM_FLOORS-1:0] set_c;
  logic [NUM_FLOORS-1:0] req_q;
  logic [NUM_FLOORS-1:0] req_d;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       cnt_d;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
    button_debouncer #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debouncer (
      .CLK        (CLK),
      .RST        (RST),
      .interior_i (interior_panel[f]),
      .exterior_i (exterior_panel[f]),
      .rise_c     (set_c[f])
    );
  end

  // An open door clears its floor and overrides a simultaneous new call.
  always_comb begin
    req_d = (req_q | set_c) & ~doors;
    cnt_d = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      cnt_d = cnt_d + CntW'(req_d[f]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  end

  assign requests  = req_q;
  assign req_count = cnt_q;

endmodule

// File: tb/tb_call_register.sv
// Bench for call_register; latency expectations follow CALL_REGISTER_DEBOUNCE_EN.
module tb_call_register;

  localparam int NF   = 3;
  localparam int DB   = 4;
  localparam int HIST = DB + 2;
`ifdef CALL_REGISTER_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic          CLK;
  logic          RST;
  logic [NF-1:0] interior;
  logic [NF-1:0] exterior;
  logic [NF-1:0] doors;
  logic [NF-1:0] requests;
  logic [1:0]    req_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: raw press history; a level changes once a full window of samples agrees.
  logic [NF-1:0] hist [HIST];
  logic [NF-1:0] mdl_lvl_q;
  logic [NF-1:0] mdl_lvl_d;
  logic [NF-1:0] exp_req;

  call_register #(
    .NUM_FLOORS (NF),
    .DB_CYCLES  (DB)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .interior_panel (interior),
    .exterior_panel (exterior),
    .doors          (doors),
    .requests       (requests),
    .req_count      (req_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    logic stable;
    mdl_lvl_d = mdl_lvl_q;
    stable    = 1'b1;
`ifdef CALL_REGISTER_DEBOUNCE_EN
    for (int f = 0; f < NF; f++) begin
      stable = 1'b1;
      for (int j = 2; j < HIST; j++) begin
        if (hist[j][f] != hist[1][f]) stable = 1'b0;
      end
      if (stable) mdl_lvl_d[f] = hist[1][f];
    end
`else
    mdl_lvl_d = hist[1];
`endif
  end

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < HIST; i++) hist[i] <= '0;
      mdl_lvl_q <= '0;
      exp_req   <= '0;
    end else begin
      hist[0] <= interior | exterior;
      for (int i = 1; i < HIST; i++) hist[i] <= hist[i-1];
      mdl_lvl_q <= mdl_lvl_d;
      exp_req   <= (exp_req | (mdl_lvl_d & ~mdl_lvl_q)) & ~doors;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0; interior = '0; exterior = '0; doors = '0;
    tick(2);
    RST = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    RST = 1'b0; interior = 3'b111; exterior = 3'b111; doors = '0;
    tick(4);
    n_cmp++;
    if (requests !== 3'b000 || req_count !== 2'd0) begin
      n_bad++;
      $display("FAIL reset: requests=%b count=%0d, want 000/0", requests, req_count);
    end
    RST = 1'b1; interior = '0; exterior = '0;
    tick(1);
  endtask

  task automatic test_clean_press();
    logic [NF-1:0] want;
    do_reset();
    interior = 3'(1 << elevator_pkg::FLOOR_3);
    for (int e = 1; e <= LAT + 2; e++) begin
      tick(1);
      want = (e >= LAT) ? 3'b100 : 3'b000;
      n_cmp++;
      if (requests !== want || requests !== exp_req) begin
        n_bad++;
        $display("FAIL clean_press edge %0d: requests=%b want %b model %b", e, requests, want, exp_req);
      end
    end
  endtask

  task automatic test_bounce();
    logic [NF-1:0] want;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      exterior = (i % 2 == 0) ? 3'b010 : 3'b000;
      tick(1);
      n_cmp++;
      if (requests !== exp_req) begin
        n_bad++;
        $display("FAIL bounce_model cyc %0d: requests=%b model %b", i, requests, exp_req);
      end
`ifdef CALL_REGISTER_DEBOUNCE_EN
      n_cmp++;
      if (requests !== 3'b000) begin
        n_bad++;
        $display("FAIL bounce_quiet cyc %0d: requests=%b want 000", i, requests);
      end
`endif
    end
    exterior = 3'(1 << elevator_pkg::FLOOR_2);
    for (int e = 1; e <= LAT + 1; e++) begin
      tick(1);
      n_cmp++;
      if (requests !== exp_req) begin
        n_bad++;
        $display("FAIL bounce_hold_model edge %0d: requests=%b model %b", e, requests, exp_req);
      end
`ifdef CALL_REGISTER_DEBOUNCE_EN
      want = (e >= LAT) ? 3'b010 : 3'b000;
      n_cmp++;
      if (requests !== want) begin
        n_bad++;
        $display("FAIL bounce_hold edge %0d: requests=%b want %b", e, requests, want);
      end
`endif
    end
  endtask

  task automatic test_service();
    do_reset();
    interior = 3'b011;
    tick(LAT + 1);
    n_cmp++;
    if (requests !== 3'b011 || req_count !== 2'd2) begin
      n_bad++;
      $display("FAIL service_setup: requests=%b count=%0d want 011/2", requests, req_count);
    end
    doors = 3'(1 << elevator_pkg::FLOOR_1);
    tick(1);
    doors = '0;
    n_cmp++;
    if (requests !== 3'b010 || req_count !== 2'd1) begin
      n_bad++;
      $display("FAIL service_clear: requests=%b count=%0d want 010/1", requests, req_count);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      n_cmp++;
      if (requests !== 3'b010 || requests !== exp_req) begin
        n_bad++;
        $display("FAIL service_held cyc %0d: requests=%b want 010 model %b", i, requests, exp_req);
      end
    end
    interior = 3'b010;
    tick(LAT + 2);
    interior = 3'b011;
    tick(LAT - 1);
    n_cmp++;
    if (requests !== 3'b010) begin
      n_bad++;
      $display("FAIL service_repress_early: requests=%b want 010", requests);
    end
    tick(1);
    n_cmp++;
    if (requests !== 3'b011 || req_count !== 2'd2) begin
      n_bad++;
      $display("FAIL service_repress: requests=%b count=%0d want 011/2", requests, req_count);
    end
  endtask

  task automatic test_collision();
    do_reset();
    doors    = 3'b010;
    interior = 3'b010;
    exterior = 3'b100;
    tick(LAT + 2);
    n_cmp++;
    if (requests !== 3'b100 || req_count !== 2'd1) begin
      n_bad++;
      $display("FAIL collision: requests=%b count=%0d want 100/1", requests, req_count);
    end
    doors = '0;
    tick(3);
    n_cmp++;
    if (requests !== 3'b100 || requests !== exp_req) begin
      n_bad++;
      $display("FAIL collision_after: requests=%b want 100 model %b", requests, exp_req);
    end
  endtask

  task automatic test_reset_mid();
    logic [NF-1:0] want;
    do_reset();
    exterior = 3'b100;
    tick(LAT + 1);
    interior = 3'b001;
    tick(2);
    #2 RST = 1'b0;
    #1;
    n_cmp++;
    if (requests !== 3'b000 || req_count !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_async: requests=%b count=%0d want 000/0", requests, req_count);
    end
    tick(2);
    RST = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      tick(1);
      want = (e >= LAT) ? 3'b101 : 3'b000;
      n_cmp++;
      if (requests !== want || requests !== exp_req) begin
        n_bad++;
        $display("FAIL reset_repress edge %0d: requests=%b want %b model %b", e, requests, want, exp_req);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) interior ^= 3'(1 << $urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) exterior ^= 3'(1 << $urandom_range(0, 2));
      doors = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      tick(1);
      n_cmp++;
      if (requests !== exp_req || req_count !== 2'($countones(exp_req))) begin
        n_bad++;
        $display("FAIL random cyc %0d: requests=%b count=%0d model %b/%0d",
                 i, requests, req_count, exp_req, $countones(exp_req));
      end
    end
  endtask

  initial begin
    RST = 1'b0; interior = '0; exterior = '0; doors = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_service();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
